calc_input_sequencer: RTL and testbench
=======================================

Name: calc_input_sequencer

Overview:
- Upstream stage of display_control. It debounces the Basys3 push-buttons and sequences operand entry from sw[3:0].
- It selects the operator, computes the 4-bit result, and drives confirmed_operand1, confirmed_operand2 and result into the display block.
- BTND is not consumed here; it goes straight to display_control for the dec/hex mode toggle.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable synchronised samples needed before a button level is accepted (1 ms at 50 MHz). Testbenches override it to 4.
- CNT_W, 16, width of each debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- BTNC  in  1  raw confirm button (asynchronous, bouncy)
- BTNU  in  1  raw operator-cycle button
- BTNL  in  1  raw clear button
- sw  in  4  operand entry switches
- operand1  out  4  latched operand A
- operand2  out  4  latched operand B
- op  out  2  operator: 00 ADD, 01 SUB, 10 MUL, 11 AND
- confirmed_operand1  out  1  operand A latched
- confirmed_operand2  out  1  operand B latched
- result  out  4  computed result, low 4 bits
- overflow  out  1  true result outside 0..15
- state  out  2  00 ENTER_A, 01 ENTER_B, 10 COMPUTE, 11 SHOW

Behaviour:
- Reset: all outputs 0, state ENTER_A, debounced levels 0, counters 0, synchroniser flops 0.
- Per-button conditioner (BTNC, BTNU, BTNL):
  - 2-flop synchroniser feeds a counter. The counter increments while the synchronised value differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - A rise of the debounced level produces a 1-cycle press pulse.
  - Latency: raw level first sampled at edge N; press pulse is high for the cycle after edge N+1+DEBOUNCE_CYCLES; the FSM acts at edge N+2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no pulse.
  - Holding a button produces exactly one pulse; release is debounced the same way and produces no pulse.
- FSM, evaluated on press pulses only:
  - ENTER_A:
    - confirm: operand1<=sw, confirmed_operand1<=1, go to ENTER_B.
    - opcycle: op<=op+1 (wraps 11->00).
  - ENTER_B:
    - confirm: operand2<=sw, confirmed_operand2<=1, go to COMPUTE.
    - opcycle: op<=op+1.
  - COMPUTE (exactly 1 cycle, unconditional): result and overflow registered, go to SHOW.
    - ADD: a+b; overflow if the sum exceeds 15.
    - SUB: a-b mod 16; overflow if a<b.
    - MUL: low 4 bits of the 8-bit product; overflow if product[7:4] is non-zero.
    - AND: a&b; overflow=0.
  - SHOW:
    - confirm: both confirmed flags, result and overflow cleared; operands and op kept; go to ENTER_A.
    - opcycle: ignored.
- Clear pulse, in any state: operands, flags, result, overflow and op all go to 0, state ENTER_A. It takes priority over confirm or opcycle pulses in the same cycle.
- Confirm and opcycle pulses in the same cycle (ENTER_A/ENTER_B): both take effect. The op increment and the operand latch happen on the same edge.
- Pulses arriving during COMPUTE are dropped, except clear, which still applies.
- sw is sampled only on the confirm edge. Changes to sw at any other time have no effect on the outputs.
- Reset asserted mid-debounce or mid-sequence:
  - Next edge gives reset values.
  - A button still held when reset releases is re-debounced and produces a pulse DEBOUNCE_CYCLES+2 edges later.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then sw=4'hA, hold BTNC for 10 cycles -> single pulse; operand1=A, confirmed_operand1=1, state=01 at the 6th edge after the first sample.
- BTNC bounce pattern 1,0,1,1,0 then low -> no pulse; state unchanged at 00.
- Add overflow: op=ADD, A=4'hA, B=4'h3 -> result=D, overflow=0.
  - Repeat with B=4'h9 -> result=3, overflow=1. Both values valid one cycle after entering COMPUTE.
- Sub and mul:
  - BTNU pressed once, then A=2, B=5 -> op=01, result=D, overflow=1.
  - BTNU pressed twice more, then A=3, B=5 -> op=11, result=1.
  - op=10 with A=4, B=4 -> result=0, overflow=1.
- Clear priority: in SHOW, BTNC and BTNL pulses land on the same edge -> all outputs 0, state 00.
- Reset mid-sequence: in ENTER_B, assert reset for 1 cycle -> every output 0 at the next edge.

Source files
------------

// File: rtl/calc_input_sequencer.sv
// Input stage for the Basys3 calculator: debounces BTNC/BTNU/BTNL, sequences
// operand entry from the switches and registers the 4-bit result for display_control.

module calc_button_conditioner #(
  parameter int               CNT_W = 16,
  parameter logic [CNT_W-1:0] LAST  = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] count;

  // A new level is accepted only after LAST+1 consecutive differing samples;
  // the press pulse is registered on the same edge the level rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      count <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        count <= '0;
      end else if (count == LAST) begin
        level <= sync2;
        count <= '0;
        press <= sync2;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

module calc_input_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTNC,
  input  logic       BTNU,
  input  logic       BTNL,
  input  logic [3:0] sw,
  output logic [3:0] operand1,
  output logic [3:0] operand2,
  output logic [1:0] op,
  output logic       confirmed_operand1,
  output logic       confirmed_operand2,
  output logic [3:0] result,
  output logic       overflow,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    COMPUTE = 2'b10,
    SHOW    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  state_t     cur_state;
  logic       confirm_press;
  logic       opcycle_press;
  logic       clear_press;
  logic [4:0] sum;
  logic [7:0] product;
  logic [3:0] next_result;
  logic       next_overflow;

  calc_button_conditioner #(.CNT_W(CNT_W), .LAST(LAST)) u_confirm (
    .clk   (clk),
    .reset (reset),
    .raw   (BTNC),
    .press (confirm_press)
  );

  calc_button_conditioner #(.CNT_W(CNT_W), .LAST(LAST)) u_opcycle (
    .clk   (clk),
    .reset (reset),
    .raw   (BTNU),
    .press (opcycle_press)
  );

  calc_button_conditioner #(.CNT_W(CNT_W), .LAST(LAST)) u_clear (
    .clk   (clk),
    .reset (reset),
    .raw   (BTNL),
    .press (clear_press)
  );

  // Overflow means the true arithmetic result does not fit in 0..15.
  always_comb begin
    sum           = {1'b0, operand1} + {1'b0, operand2};
    product       = {4'b0000, operand1} * {4'b0000, operand2};
    next_result   = 4'h0;
    next_overflow = 1'b0;
    case (op)
      2'b00: begin
        next_result   = sum[3:0];
        next_overflow = sum[4];
      end
      2'b01: begin
        next_result   = operand1 - operand2;
        next_overflow = (operand1 < operand2);
      end
      2'b10: begin
        next_result   = product[3:0];
        next_overflow = (product[7:4] != 4'h0);
      end
      default: begin
        next_result   = operand1 & operand2;
        next_overflow = 1'b0;
      end
    endcase
  end

  // Clear outranks every other pulse; COMPUTE lasts one cycle and drops pulses.
  always_ff @(posedge clk) begin
    if (reset || clear_press) begin
      cur_state          <= ENTER_A;
      operand1           <= 4'h0;
      operand2           <= 4'h0;
      op                 <= 2'b00;
      confirmed_operand1 <= 1'b0;
      confirmed_operand2 <= 1'b0;
      result             <= 4'h0;
      overflow           <= 1'b0;
    end else begin
      case (cur_state)
        ENTER_A: begin
          if (opcycle_press) op <= op + 2'b01;
          if (confirm_press) begin
            operand1           <= sw;
            confirmed_operand1 <= 1'b1;
            cur_state          <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (opcycle_press) op <= op + 2'b01;
          if (confirm_press) begin
            operand2           <= sw;
            confirmed_operand2 <= 1'b1;
            cur_state          <= COMPUTE;
          end
        end
        COMPUTE: begin
          result    <= next_result;
          overflow  <= next_overflow;
          cur_state <= SHOW;
        end
        default: begin
          if (confirm_press) begin
            confirmed_operand1 <= 1'b0;
            confirmed_operand2 <= 1'b0;
            result             <= 4'h0;
            overflow           <= 1'b0;
            cur_state          <= ENTER_A;
          end
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed bench for calc_input_sequencer with DEBOUNCE_CYCLES=4.

module tb_calc_input_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       BTNC = 1'b0;
  logic       BTNU = 1'b0;
  logic       BTNL = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [3:0] operand1;
  logic [3:0] operand2;
  logic [1:0] op;
  logic       confirmed_operand1;
  logic       confirmed_operand2;
  logic [3:0] result;
  logic       overflow;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  calc_input_sequencer #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .BTNC               (BTNC),
    .BTNU               (BTNU),
    .BTNL               (BTNL),
    .sw                 (sw),
    .operand1           (operand1),
    .operand2           (operand2),
    .op                 (op),
    .confirmed_operand1 (confirmed_operand1),
    .confirmed_operand2 (confirmed_operand2),
    .result             (result),
    .overflow           (overflow),
    .state              (state)
  );

  always #5 clk = ~clk;

  // Everything packed into one vector so a single compare covers all outputs.
  function automatic logic [20:0] outs();
    return {operand1, operand2, op, confirmed_operand1, confirmed_operand2,
            result, overflow, state};
  endfunction

  // Hold the selected buttons long enough for one pulse, then release and settle.
  task automatic hold_buttons(input logic c, input logic u, input logic l);
    @(negedge clk);
    BTNC = c; BTNU = u; BTNL = l;
    repeat (8) @(negedge clk);
    BTNC = 1'b0; BTNU = 1'b0; BTNL = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (outs() !== 21'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h expected %h", outs(), 21'h0);
    end
  endtask

  task automatic test_glitch();
    logic pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sw = 4'h6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      BTNC = pattern[i];
    end
    BTNC = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (state !== 2'b00 || confirmed_operand1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_no_pulse got state=%b conf1=%b expected state=00 conf1=0",
               state, confirmed_operand1);
    end
  endtask

  task automatic test_single_press();
    sw = 4'hA;
    @(negedge clk);
    BTNC = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("[TB] FAIL confirm_too_early got state=%b expected 00", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'b01 || operand1 !== 4'hA || confirmed_operand1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL confirm_latency got state=%b op1=%h conf1=%b expected 01 A 1",
               state, operand1, confirmed_operand1);
    end
    repeat (3) @(negedge clk);
    BTNC = 1'b0;
    sw = 4'hF;
    repeat (12) @(negedge clk);
    checks++;
    if (state !== 2'b01 || confirmed_operand2 !== 1'b0 || operand1 !== 4'hA) begin
      errors++;
      $display("[TB] FAIL single_pulse got state=%b conf2=%b op1=%h expected 01 0 A",
               state, confirmed_operand2, operand1);
    end
  endtask

  task automatic test_add();
    do_reset();
    sw = 4'hA; hold_buttons(1'b1, 1'b0, 1'b0);
    sw = 4'h3; hold_buttons(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== {4'hA, 4'h3, 2'b00, 1'b1, 1'b1, 4'hD, 1'b0, 2'b11}) begin
      errors++;
      $display("[TB] FAIL add_no_overflow got %h expected %h", outs(),
               {4'hA, 4'h3, 2'b00, 1'b1, 1'b1, 4'hD, 1'b0, 2'b11});
    end
    hold_buttons(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== {4'hA, 4'h3, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00}) begin
      errors++;
      $display("[TB] FAIL show_confirm_return got %h expected %h", outs(),
               {4'hA, 4'h3, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00});
    end
    sw = 4'hA; hold_buttons(1'b1, 1'b0, 1'b0);
    sw = 4'h9;
    @(negedge clk);
    BTNC = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("[TB] FAIL compute_state got %b expected 10", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'b11 || result !== 4'h3 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_overflow got state=%b result=%h ovf=%b expected 11 3 1",
               state, result, overflow);
    end
    BTNC = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_sub_mul_and();
    do_reset();
    hold_buttons(1'b0, 1'b1, 1'b0);
    sw = 4'h2; hold_buttons(1'b1, 1'b0, 1'b0);
    sw = 4'h5; hold_buttons(1'b1, 1'b0, 1'b0);
    checks++;
    if (op !== 2'b01 || result !== 4'hD || overflow !== 1'b1 || state !== 2'b11) begin
      errors++;
      $display("[TB] FAIL sub got op=%b result=%h ovf=%b state=%b expected 01 D 1 11",
               op, result, overflow, state);
    end
    hold_buttons(1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'b11 || op !== 2'b01) begin
      errors++;
      $display("[TB] FAIL show_ignores_opcycle got state=%b op=%b expected 11 01", state, op);
    end
    hold_buttons(1'b1, 1'b0, 1'b0);
    hold_buttons(1'b0, 1'b1, 1'b0);
    hold_buttons(1'b0, 1'b1, 1'b0);
    sw = 4'h3; hold_buttons(1'b1, 1'b0, 1'b0);
    sw = 4'h5; hold_buttons(1'b1, 1'b0, 1'b0);
    checks++;
    if (op !== 2'b11 || result !== 4'h1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL and got op=%b result=%h ovf=%b expected 11 1 0", op, result, overflow);
    end
    hold_buttons(1'b1, 1'b0, 1'b0);
    hold_buttons(1'b0, 1'b1, 1'b0);
    checks++;
    if (op !== 2'b00) begin
      errors++;
      $display("[TB] FAIL op_wrap got %b expected 00", op);
    end
    hold_buttons(1'b0, 1'b1, 1'b0);
    hold_buttons(1'b0, 1'b1, 1'b0);
    sw = 4'h4; hold_buttons(1'b1, 1'b0, 1'b0);
    hold_buttons(1'b1, 1'b0, 1'b0);
    checks++;
    if (op !== 2'b10 || result !== 4'h0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mul got op=%b result=%h ovf=%b expected 10 0 1", op, result, overflow);
    end
  endtask

  task automatic test_clear_priority();
    hold_buttons(1'b1, 1'b0, 1'b1);
    checks++;
    if (outs() !== 21'h0) begin
      errors++;
      $display("[TB] FAIL clear_priority got %h expected %h", outs(), 21'h0);
    end
  endtask

  task automatic test_confirm_and_opcycle();
    sw = 4'h7;
    hold_buttons(1'b1, 1'b1, 1'b0);
    checks++;
    if (op !== 2'b01 || operand1 !== 4'h7 || state !== 2'b01 || confirmed_operand1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL confirm_with_opcycle got op=%b op1=%h state=%b conf1=%b expected 01 7 01 1",
               op, operand1, state, confirmed_operand1);
    end
  endtask

  task automatic test_reset_mid_sequence();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (outs() !== 21'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_sequence got %h expected %h", outs(), 21'h0);
    end
    sw = 4'hC;
    @(negedge clk);
    BTNC = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("[TB] FAIL held_after_reset_early got state=%b expected 00", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'b01 || operand1 !== 4'hC) begin
      errors++;
      $display("[TB] FAIL held_after_reset got state=%b op1=%h expected 01 C", state, operand1);
    end
    BTNC = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_press();
    test_add();
    test_sub_mul_and();
    test_clear_priority();
    test_confirm_and_opcycle();
    test_reset_mid_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
